// File: rtl/execute_unit_mc_if.sv
// execute_unit_mc_if: operand/result handshake bus of the multicycle execute unit.
// slave = execute unit, master = decode/writeback side.
interface execute_unit_mc_if #(
  parameter int DATA_W = 8
);
  localparam int SHAMT_W = $clog2(DATA_W);

  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            opcode;
  logic                  am;
  logic [SHAMT_W-1:0]    s_r_amount;
  logic [DATA_W-1:0]     operand_1;
  logic [DATA_W-1:0]     rs2_data;
  logic [DATA_W-1:0]     mem_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   result;
  logic                  zero_flag;
  logic                  carry_flag;
  logic                  ac_flag;
  logic                  parity_flag;
  logic                  div_zero;
  logic                  busy;

  modport slave (
    input  in_valid, opcode, am, s_r_amount,
    input  operand_1, rs2_data, mem_data, out_ready,
    output in_ready, out_valid, result,
    output zero_flag, carry_flag, ac_flag, parity_flag,
    output div_zero, busy
  );

  modport master (
    output in_valid, opcode, am, s_r_amount,
    output operand_1, rs2_data, mem_data, out_ready,
    input  in_ready, out_valid, result,
    input  zero_flag, carry_flag, ac_flag, parity_flag,
    input  div_zero, busy
  );
endinterface

// File: rtl/execute_unit_mc.sv
// execute_unit_mc: multicycle execute stage, 1-cycle ALU ops,
// iterative shift-add MUL and restoring DIV, held result/flags.
module execute_unit_mc #(
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              reset,
  execute_unit_mc_if.slave bus
);
  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int W = DATA_W;

  localparam logic [4:0] OP_MOV = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_MUL = 5'b00011;
  localparam logic [4:0] OP_DIV = 5'b00100;
  localparam logic [4:0] OP_INC = 5'b00101;
  localparam logic [4:0] OP_DEC = 5'b00110;
  localparam logic [4:0] OP_AND = 5'b00111;
  localparam logic [4:0] OP_OR  = 5'b01000;
  localparam logic [4:0] OP_NOT = 5'b01001;
  localparam logic [4:0] OP_XOR = 5'b01010;
  localparam logic [4:0] OP_LD  = 5'b01011;
  localparam logic [4:0] OP_ST  = 5'b01100;
  localparam logic [4:0] OP_ASL = 5'b10000;
  localparam logic [4:0] OP_ASR = 5'b10001;
  localparam logic [4:0] OP_LSL = 5'b10010;
  localparam logic [4:0] OP_LSR = 5'b10011;
  localparam logic [4:0] OP_ROL = 5'b10100;
  localparam logic [4:0] OP_ROR = 5'b10101;
  localparam logic [4:0] OP_CMP = 5'b11001;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state;
  logic [2*W-1:0]     acc;
  logic [W-1:0]       dvs;
  logic [SHAMT_W-1:0] cnt;
  logic               is_div;
  logic [2*W-1:0]     res;
  logic               zf;
  logic               cf;
  logic               af;
  logic               pf;
  logic               dz;

  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [W-1:0] src;
  assign op1 = bus.operand_1;
  assign op2 = bus.am ? bus.mem_data : bus.rs2_data;
  assign src = bus.am ? op2 : op1;

  // INC/DEC reuse the ADD/SUB datapath with src and a constant 1
  logic         incdec;
  logic [W-1:0] aa;
  logic [W-1:0] bb;
  logic [W:0]   xa;
  logic [W:0]   xb;
  logic [W:0]   sum;
  logic [W:0]   dif;
  assign incdec = (bus.opcode == OP_INC) || (bus.opcode == OP_DEC);
  assign aa  = incdec ? src : op1;
  assign bb  = incdec ? W'(1) : op2;
  assign xa  = {1'b0, aa};
  assign xb  = {1'b0, bb};
  assign sum = xa + xb;
  assign dif = xa - xb;

  // one guard bit on each side catches the last bit shifted out;
  // rotates use the negated amount so amt=0 needs no special case
  logic [SHAMT_W-1:0] amt;
  logic [SHAMT_W-1:0] namt;
  logic [W:0]         shl;
  logic [W:0]         shr;
  logic [W:0]         sar;
  logic [W-1:0]       rol;
  logic [W-1:0]       ror;
  assign amt  = bus.s_r_amount;
  assign namt = -amt;
  assign shl  = {1'b0, src} << amt;
  assign shr  = {src, 1'b0} >> amt;
  assign sar  = $signed({src, 1'b0}) >>> amt;
  assign rol  = (src << amt) | (src >> namt);
  assign ror  = (src >> amt) | (src << namt);

  logic [W-1:0] alu;
  logic         upd_zp;
  logic         upd_c;
  logic         upd_a;
  logic         c_val;
  logic         a_val;
  logic         multi;

  // single-cycle result and flag-update decode
  always_comb begin
    alu    = '0;
    upd_zp = 1'b1;
    upd_c  = 1'b0;
    upd_a  = 1'b0;
    c_val  = 1'b0;
    a_val  = 1'b0;
    multi  = 1'b0;
    case (bus.opcode)
      OP_MOV: alu = src;
      OP_ADD, OP_INC: begin
        alu   = sum[W-1:0];
        upd_c = 1'b1;
        upd_a = 1'b1;
        c_val = sum[W];
        a_val = xa[4] ^ xb[4] ^ sum[4];
      end
      OP_SUB, OP_DEC: begin
        alu   = dif[W-1:0];
        upd_c = 1'b1;
        upd_a = 1'b1;
        c_val = dif[W];
        a_val = xa[4] ^ xb[4] ^ dif[4];
      end
      OP_AND: alu = op1 & op2;
      OP_OR:  alu = op1 | op2;
      OP_XOR: alu = op1 ^ op2;
      OP_NOT: alu = ~src;
      OP_ASL, OP_LSL: begin
        alu   = shl[W-1:0];
        upd_c = 1'b1;
        c_val = shl[W];
      end
      OP_LSR: begin
        alu   = shr[W:1];
        upd_c = 1'b1;
        c_val = shr[0];
      end
      OP_ASR: begin
        alu   = sar[W:1];
        upd_c = 1'b1;
        c_val = sar[0];
      end
      OP_ROL: alu = rol;
      OP_ROR: alu = ror;
      OP_CMP: alu = {{(W-1){1'b0}}, op1 >= op2};
      OP_LD: begin
        alu    = bus.mem_data;
        upd_zp = 1'b0;
      end
      OP_ST: begin
        alu    = op1;
        upd_zp = 1'b0;
      end
      OP_MUL, OP_DIV: begin
        multi  = 1'b1;
        upd_zp = 1'b0;
      end
      default: upd_zp = 1'b0;
    endcase
  end

  // one MUL/DIV step; acc holds {partial/remainder, multiplier/quotient}
  logic [W:0]     msum;
  logic [2*W-1:0] mnxt;
  logic [W:0]     dsh;
  logic           ge;
  logic [W-1:0]   dsub;
  logic [2*W-1:0] dnxt;
  logic [2*W-1:0] nxt;
  logic           last;
  assign msum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, dvs} : '0);
  assign mnxt = {msum, acc[W-1:1]};
  assign dsh  = {acc[2*W-1:W], acc[W-1]};
  assign ge   = dsh >= {1'b0, dvs};
  assign dsub = dsh[W-1:0] - dvs;
  assign dnxt = {ge ? dsub : dsh[W-1:0], acc[W-2:0], ge};
  assign nxt  = is_div ? dnxt : mnxt;
  assign last = cnt == SHAMT_W'(W - 1);

  // control FSM with registered result, flags and iteration state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      res    <= '0;
      zf     <= 1'b0;
      cf     <= 1'b0;
      af     <= 1'b0;
      pf     <= 1'b0;
      dz     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (multi) begin
              state  <= BUSY;
              cnt    <= '0;
              is_div <= bus.opcode == OP_DIV;
              if (bus.opcode == OP_DIV) begin
                acc <= {{W{1'b0}}, op1};
                dvs <= op2;
              end else begin
                acc <= {{W{1'b0}}, op2};
                dvs <= op1;
              end
            end else begin
              state <= DONE;
              res   <= {{W{1'b0}}, alu};
              if (upd_zp) begin
                zf <= alu == '0;
                pf <= ^alu;
              end
              if (upd_c) cf <= c_val;
              if (upd_a) af <= a_val;
            end
          end
        end
        BUSY: begin
          acc <= nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            res   <= nxt;
            zf    <= nxt == '0;
            pf    <= ^nxt;
            cf    <= 1'b0;
            af    <= 1'b0;
            if (is_div) dz <= dvs == '0;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = state == IDLE;
  assign bus.busy        = state == BUSY;
  assign bus.out_valid   = state == DONE;
  assign bus.result      = res;
  assign bus.zero_flag   = zf;
  assign bus.carry_flag  = cf;
  assign bus.ac_flag     = af;
  assign bus.parity_flag = pf;
  assign bus.div_zero    = dz;
endmodule

// File: tb/tb_execute_unit_mc.sv
// tb_execute_unit_mc: directed tests for execute_unit_mc, DATA_W=8.
// Flags compared as {zero, carry, ac, parity}.
module tb_execute_unit_mc;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  execute_unit_mc_if #(.DATA_W(8)) bus ();

  execute_unit_mc #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  localparam logic [4:0] MOV = 5'b00000;
  localparam logic [4:0] ADD = 5'b00001;
  localparam logic [4:0] SUB = 5'b00010;
  localparam logic [4:0] MUL = 5'b00011;
  localparam logic [4:0] DIV = 5'b00100;
  localparam logic [4:0] INC = 5'b00101;
  localparam logic [4:0] DEC = 5'b00110;
  localparam logic [4:0] OR  = 5'b01000;
  localparam logic [4:0] NOT = 5'b01001;
  localparam logic [4:0] LD  = 5'b01011;
  localparam logic [4:0] ASL = 5'b10000;
  localparam logic [4:0] ASR = 5'b10001;
  localparam logic [4:0] LSL = 5'b10010;
  localparam logic [4:0] LSR = 5'b10011;
  localparam logic [4:0] ROL = 5'b10100;
  localparam logic [4:0] ROR = 5'b10101;
  localparam logic [4:0] CMP = 5'b11001;
  localparam logic [4:0] UND = 5'b11010;

  int checks = 0;
  int errors = 0;

  logic [3:0] flg;
  assign flg = {bus.zero_flag, bus.carry_flag, bus.ac_flag, bus.parity_flag};

  task automatic drive(input logic [4:0] op, input logic m,
                       input logic [2:0] sa, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] md);
    bus.opcode     = op;
    bus.am         = m;
    bus.s_r_amount = sa;
    bus.operand_1  = a;
    bus.rs2_data   = b;
    bus.mem_data   = md;
  endtask

  // issue one op, return posedges from accept (inclusive) to out_valid
  task automatic run_op(input logic [4:0] op, input logic m,
                        input logic [2:0] sa, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] md,
                        output int lat, output int bz);
    int n = 0;
    @(negedge clk);
    drive(op, m, sa, a, b, md);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    lat = 1;
    bz = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) bz++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(MOV, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.div_zero} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0100",
               {bus.out_valid, bus.in_ready, bus.busy, bus.div_zero});
    end
    checks++;
    if (bus.result !== 16'h0000 || flg !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got %h/%b want 0000/0000", bus.result, flg);
    end
  endtask

  task automatic test_add();
    int lat, bz;
    run_op(ADD, 1'b0, 3'd0, 8'hF8, 8'h0A, 8'h00, lat, bz);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL add_latency got %0d want 1", lat);
    end
    checks++;
    if (bus.result !== 16'h0002 || flg !== 4'b0111) begin
      errors++;
      $display("FAIL add_result got %h/%b want 0002/0111", bus.result, flg);
    end
    release_out();
  endtask

  task automatic test_mul();
    int lat, bz;
    run_op(MUL, 1'b0, 3'd0, 8'hFF, 8'hFF, 8'h00, lat, bz);
    checks++;
    if (lat !== 9 || bz !== 8) begin
      errors++;
      $display("FAIL mul_timing got lat %0d busy %0d want 9 8", lat, bz);
    end
    checks++;
    if (bus.result !== 16'hFE01 || flg !== 4'b0000) begin
      errors++;
      $display("FAIL mul_result got %h/%b want fe01/0000", bus.result, flg);
    end
    release_out();
  endtask

  task automatic test_div();
    int lat, bz;
    run_op(DIV, 1'b0, 3'd0, 8'd200, 8'd7, 8'h00, lat, bz);
    checks++;
    if (lat !== 9 || bus.result !== 16'h041C || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL div_200_7 got %0d %h %b want 9 041c 0",
               lat, bus.result, bus.div_zero);
    end
    release_out();
    run_op(DIV, 1'b0, 3'd0, 8'h55, 8'h00, 8'h00, lat, bz);
    checks++;
    if (lat !== 9 || bus.result !== 16'h55FF || bus.div_zero !== 1'b1) begin
      errors++;
      $display("FAIL div_by_zero got %0d %h %b want 9 55ff 1",
               lat, bus.result, bus.div_zero);
    end
    checks++;
    if (flg !== 4'b0000) begin
      errors++;
      $display("FAIL div_flags got %b want 0000", flg);
    end
    release_out();
    run_op(DIV, 1'b0, 3'd0, 8'h09, 8'h03, 8'h00, lat, bz);
    checks++;
    if (bus.result !== 16'h0003 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL div_clear got %h %b want 0003 0",
               bus.result, bus.div_zero);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat, bz;
    run_op(ADD, 1'b0, 3'd0, 8'h0F, 8'h01, 8'h00, lat, bz);
    drive(SUB, 1'b0, 3'd0, 8'h00, 8'h01, 8'h00);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.result !== 16'h0010 || flg !== 4'b0011 ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d got %h/%b rdy %b vld %b want 0010/0011 0 1",
                 i, bus.result, flg, bus.in_ready, bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain got vld %b rdy %b want 0 1",
               bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 16'h00FF || flg !== 4'b0110) begin
      errors++;
      $display("FAIL next_sub got %b %h/%b want 1 00ff/0110",
               bus.out_valid, bus.result, flg);
    end
    release_out();
  endtask

  task automatic test_reset_midop();
    int lat, bz;
    int seen = 0;
    @(negedge clk);
    drive(MUL, 1'b0, 3'd0, 8'h12, 8'h34, 8'h00);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b want 1", bus.busy);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        flg !== 4'b0000 || bus.result !== 16'h0000) begin
      errors++;
      $display("FAIL abort got vld %b rdy %b %h/%b want 0 1 0000/0000",
               bus.out_valid, bus.in_ready, bus.result, flg);
    end
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d valid cycles want 0", seen);
    end
    run_op(INC, 1'b0, 3'd0, 8'h0F, 8'h00, 8'h00, lat, bz);
    checks++;
    if (lat !== 1 || bus.result !== 16'h0010 || flg !== 4'b0011) begin
      errors++;
      $display("FAIL inc got %0d %h/%b want 1 0010/0011",
               lat, bus.result, flg);
    end
    release_out();
  endtask

  task automatic test_shift_rotate();
    logic [4:0]  ops  [6] = '{LSR, ROL, LSL, ASR, ASL, ROR};
    logic [2:0]  amts [6] = '{3'd1, 3'd1, 3'd0, 3'd2, 3'd1, 3'd1};
    logic [15:0] exp  [6] = '{16'h0040, 16'h0003, 16'h0081,
                              16'h00E0, 16'h0002, 16'h00C0};
    logic [3:0]  ef   [6] = '{4'b0111, 4'b0110, 4'b0010,
                              4'b0011, 4'b0111, 4'b0110};
    int lat, bz;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], 1'b0, amts[i], 8'h81, 8'h00, 8'h00, lat, bz);
      checks++;
      if (bus.result !== exp[i] || flg !== ef[i]) begin
        errors++;
        $display("FAIL shift_%0d got %h/%b want %h/%b",
                 i, bus.result, flg, exp[i], ef[i]);
      end
      release_out();
    end
  endtask

  task automatic test_misc();
    logic [4:0]  ops [8] = '{MOV, CMP, LD, UND, NOT, OR, DEC, ADD};
    logic        ams [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0]  a   [8] = '{8'h77, 8'h05, 8'h66, 8'h33,
                             8'h00, 8'hA0, 8'h10, 8'h01};
    logic [7:0]  b   [8] = '{8'h00, 8'h05, 8'h00, 8'h44,
                             8'h00, 8'h01, 8'h00, 8'h00};
    logic [7:0]  md  [8] = '{8'h00, 8'h00, 8'h00, 8'h00,
                             8'h0F, 8'h00, 8'h00, 8'hFF};
    logic [15:0] exp [8] = '{16'h0000, 16'h0001, 16'h0000, 16'h0000,
                             16'h00F0, 16'h00A1, 16'h000F, 16'h0000};
    logic [3:0]  ef  [8] = '{4'b1110, 4'b0111, 4'b0111, 4'b0111,
                             4'b0110, 4'b0111, 4'b0010, 4'b1110};
    int lat, bz;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], ams[i], 3'd0, a[i], b[i], md[i], lat, bz);
      checks++;
      if (lat !== 1 || bus.result !== exp[i] || flg !== ef[i]) begin
        errors++;
        $display("FAIL misc_%0d got %0d %h/%b want 1 %h/%b",
                 i, lat, bus.result, flg, exp[i], ef[i]);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_midop();
    test_shift_rotate();
    test_misc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_unit_mc.md
Name: execute_unit_mc

Overview:
Parametrised, multicycle successor of the single-cycle execute stage. It sits between the operand-fetch/decode stage and writeback, and accepts one operation per valid/ready handshake. Single-cycle ALU ops complete with 1-cycle registered latency. MUL (shift-add) and DIV (restoring) are iterative over DATA_W cycles. Result and flags are registered and held until downstream accepts them.

Parameters:
DATA_W, 8, operand width in bits (must be ≥4 and a power of two).
SHAMT_W, $clog2(DATA_W), shift-amount width (localparam, derived).

Ports:
clk  input  1  clock; all state changes on posedge.
reset  input  1  synchronous, active-low reset: sampled on posedge clk, state cleared when reset==0.
in_valid  input  1  upstream has an op on the input bus.
in_ready  output  1  unit can accept an op; high only in IDLE.
opcode  input  5  operation code (encoding below).
am  input  1  addressing mode: 0 → operand_2=rs2_data, 1 → operand_2=mem_data.
s_r_amount  input  SHAMT_W  shift/rotate amount.
operand_1  input  DATA_W  first operand (register data).
rs2_data  input  DATA_W  register second operand.
mem_data  input  DATA_W  memory second operand / load data.
out_valid  output  1  result and flags are valid.
out_ready  input  1  downstream accepts the result.
result  output  2*DATA_W  result; upper half used only by MUL/DIV, otherwise zero.
zero_flag, carry_flag, ac_flag, parity_flag  output  1 each  registered status flags.
div_zero  output  1  last completed DIV had divisor 0.
busy  output  1  high in BUSY state.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; out_valid=0; result=0; all flags=0; div_zero=0; iteration counter=0. Reset aborts any in-flight op, and that op's result is never presented.
- FSM has three states: IDLE, BUSY, DONE.
- Accept: in IDLE, in_valid=1 → capture opcode, am, s_r_amount, operand_1, and operand_2 (muxed by am) at that posedge.
- Single-cycle ops go IDLE→DONE; out_valid=1 the cycle after accept.
- MUL (00011) and DIV (00100) go IDLE→BUSY. BUSY runs exactly DATA_W iterations, then →DONE. out_valid rises DATA_W+1 posedges after the accept edge.
- DONE: result and flags are held stable while out_ready=0. When out_valid && out_ready at a posedge → IDLE.
- in_ready=0 in BUSY/DONE; in_valid is ignored there. There is no overlap, so throughput is at most one op per 2 cycles.
- Unary source: "src" = (am ? operand_2 : operand_1).
- Opcodes and flag rules:
  - 00000 MOV: result = src.
  - 00001 ADD: carry = bit DATA_W of the sum; ac = carry out of bit 3.
  - 00010 SUB: carry = borrow (operand_1 < operand_2); ac = borrow from bit 3.
  - 00101 INC: src+1. 00110 DEC: src−1. Both set carry/ac as ADD/SUB.
  - 00111 AND, 01000 OR, 01010 XOR: operand_1 op operand_2. 01001 NOT: ~src.
  - 10000 ASL and 10010 LSL: src << amt; carry = last bit shifted out.
  - 10001 ASR (sign-fill) and 10011 LSR (zero-fill): carry = last bit shifted out of bit 0.
  - Any shift with amt=0: result=src, carry=0.
  - 10100 ROL, 10101 ROR: rotate src by amt; carry held.
  - 11001 CMP: result = {0…0, operand_1 >= operand_2}.
  - 00011 MUL: unsigned full 2*DATA_W product.
  - 00100 DIV: unsigned; result = {remainder, quotient}.
  - DIV with operand_2=0: quotient = all ones, remainder = operand_1, div_zero=1. It still takes DATA_W cycles. div_zero is cleared by the next completed DIV with a nonzero divisor.
  - 01011 LOAD: result = mem_data. 01100 STORE: result = operand_1. Both hold all flags.
  - 01101 JMP, 01110/10110/10111/11000 branches, 11111 HALT, and all undefined opcodes: result=0, all flags held, 1-cycle completion.
- Flag update scope:
  - zero and parity update on every result-producing op except LOAD/STORE.
  - Evaluation width is 2*DATA_W for MUL/DIV and low DATA_W otherwise.
  - parity = XOR-reduce of that width (1 = odd number of ones).
  - carry/ac are held for ops not listed as setting them; MUL/DIV clear carry and ac.
- Flags become visible together with out_valid and never change while out_valid=1.

Test Plan:
1. ADD, DATA_W=8, am=0, op1=0xF8, rs2=0x0A → one cycle after accept: result=0x0002, carry=1, ac=1, zero=0, parity=1.
2. MUL op1=0xFF, op2=0xFF → out_valid exactly 9 posedges after accept; result=0xFE01, zero=0, parity=0; busy=1 for 8 cycles.
3. DIV: 200/7 → result=0x041C, div_zero=0. Then 0x55/0 → result=0x55FF, div_zero=1.
4. Backpressure: ADD completes, out_ready held 0 for 3 cycles while in_valid=1 with new data → result and flags unchanged, in_ready=0, new op not accepted until the cycle after out_ready=1.
5. Reset: reset=0 on the 4th BUSY cycle of a MUL → next cycle out_valid=0, flags=0, in_ready=1. A following INC of 0x0F is accepted and gives 0x10 with ac=1.
6. Shift and rotate on 0x81:
   - LSR by 1 → 0x40, carry=1.
   - ASR by 2 → 0xE0, carry=0.
   - ROL by 1 → 0x03, carry unchanged from the prior op.
   - LSL by 0 → 0x81, carry=0.
